// File: rtl/io_input_conditioner.sv
// ============================================================================
// Module   : io_input_conditioner
// Brief    : Switch/button synchronizer, debouncer and key-press edge detector
//            feeding the CPU I/O input CSR. Optional macro: IO_KEY_REPEAT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_input_conditioner #(
    parameter int SW_WIDTH        = 18,
    parameter int KEY_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW_WIDTH-1:0]  sw_raw,
    input  logic [KEY_WIDTH-1:0] key_raw,
    output logic [SW_WIDTH-1:0]  sw_stable,
    output logic [KEY_WIDTH-1:0] key_stable,
    output logic [KEY_WIDTH-1:0] key_press,
    output logic [31:0]          io_word,
    output logic                 sw_changed,
    input  logic                 sw_ack
);

    localparam int N_BITS = SW_WIDTH + KEY_WIDTH;
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
    logic [KEY_WIDTH-1:0] key_s1, key_s2;
    logic [N_BITS-1:0]    d_all, stable_all, upd;
    logic [KEY_WIDTH-1:0] key_upd, key_next, key_rise, key_press_nxt;
    logic                 sw_upd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
            key_s1 <= key_raw;
            key_s2 <= key_s1;
        end
    end

    // Keys and switches share one debounce array; keys are flipped to active-high first.
    assign d_all = {~key_s2, sw_s2};

    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;

        assign upd[i] = (d_all[i] != stable_all[i]) && (cnt == CNT_MAX);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (d_all[i] == stable_all[i] || cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_all <= '0;
        end else begin
            stable_all <= stable_all ^ upd;
        end
    end

    assign sw_stable  = stable_all[SW_WIDTH-1:0];
    assign key_stable = stable_all[N_BITS-1:SW_WIDTH];
    assign io_word    = 32'(sw_stable);

    assign sw_upd   = |upd[SW_WIDTH-1:0];
    assign key_upd  = upd[N_BITS-1:SW_WIDTH];
    assign key_next = key_stable ^ key_upd;
    assign key_rise = key_upd & ~key_stable;

`ifdef IO_KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [KEY_WIDTH-1:0] rep_hit;

    for (genvar k = 0; k < KEY_WIDTH; k++) begin : g_rep
        logic [REP_W-1:0] rcnt;
        logic             rphase;
        logic [REP_W-1:0] rtgt;

        // First interval is the hold delay, later intervals the repeat period.
        assign rtgt       = rphase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
        assign rep_hit[k] = key_stable[k] && key_next[k] && (rcnt == rtgt);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rcnt   <= '0;
                rphase <= 1'b0;
            end else if (!key_next[k]) begin
                rcnt   <= '0;
                rphase <= 1'b0;
            end else if (key_stable[k]) begin
                if (rep_hit[k]) begin
                    rcnt   <= '0;
                    rphase <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end

    assign key_press_nxt = key_rise | rep_hit;
`else
    assign key_press_nxt = key_rise;
`endif

    // A switch update in the same cycle as an ack keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_press  <= '0;
            sw_changed <= 1'b0;
        end else begin
            key_press <= key_press_nxt;
            if (sw_upd) begin
                sw_changed <= 1'b1;
            end else if (sw_ack) begin
                sw_changed <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
// ============================================================================
// Module   : tb_io_input_conditioner
// Brief    : Scoreboard bench for io_input_conditioner (DEBOUNCE_CYCLES=4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_input_conditioner;

    localparam int SW_W = 18;
    localparam int KEY_W = 4;
    localparam int DEB = 4;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int HIST = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [SW_W-1:0]  sw_raw = '0;
    logic [KEY_W-1:0] key_raw = '1;
    logic             sw_ack = 1'b0;
    logic [SW_W-1:0]  sw_stable;
    logic [KEY_W-1:0] key_stable;
    logic [KEY_W-1:0] key_press;
    logic [31:0]      io_word;
    logic             sw_changed;

    io_input_conditioner #(
        .SW_WIDTH        (SW_W),
        .KEY_WIDTH       (KEY_W),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .key_raw    (key_raw),
        .sw_stable  (sw_stable),
        .key_stable (key_stable),
        .key_press  (key_press),
        .io_word    (io_word),
        .sw_changed (sw_changed),
        .sw_ack     (sw_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW_W-1:0]  sw;
        logic [KEY_W-1:0] ks;
        logic [KEY_W-1:0] kp;
        logic [31:0]      io;
        logic             ch;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: raw samples as seen at each clock edge, newest last.
    logic [SW_W-1:0]  sw_h[$];
    logic [KEY_W-1:0] key_h[$];
    logic [SW_W-1:0]  m_sw;
    logic [KEY_W-1:0] m_ks, m_kp;
    logic             m_ch;
    int               hold[KEY_W];
    logic [SW_W-1:0]  cur_sw = '0;
    logic [KEY_W-1:0] cur_key = '1;
    logic             cur_ack = 1'b0;
    logic             cur_rst = 1'b1;

    task automatic model_reset();
        m_sw = '0; m_ks = '0; m_kp = '0; m_ch = 1'b0;
        sw_h.delete(); key_h.delete();
        for (int i = 0; i < HIST; i++) begin
            sw_h.push_back('0);
            key_h.push_back('1);
        end
        for (int k = 0; k < KEY_W; k++) hold[k] = 0;
    endtask

    // A bit takes a new level once the synchronized input (raw from two edges
    // earlier) has shown that level on DEB consecutive edges.
    task automatic model_edge();
        logic [SW_W-1:0]  nsw;
        logic [KEY_W-1:0] nk;
        logic             all;
        if (cur_rst) begin
            model_reset();
            return;
        end
        nsw = m_sw;
        nk  = m_ks;
        for (int b = 0; b < SW_W; b++) begin
            all = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if (sw_h[sw_h.size() - j][b] == m_sw[b]) all = 1'b0;
            if (all) nsw[b] = ~m_sw[b];
        end
        for (int b = 0; b < KEY_W; b++) begin
            all = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if (~key_h[key_h.size() - j][b] == m_ks[b]) all = 1'b0;
            if (all) nk[b] = ~m_ks[b];
        end
        m_kp = nk & ~m_ks;
`ifdef IO_KEY_REPEAT_EN
        for (int k = 0; k < KEY_W; k++) begin
            if (!nk[k]) hold[k] = 0;
            else if (!m_ks[k]) hold[k] = 0;
            else begin
                hold[k]++;
                if (hold[k] == RD || (hold[k] > RD && (hold[k] - RD) % RP == 0)) m_kp[k] = 1'b1;
            end
        end
`endif
        if (nsw != m_sw) m_ch = 1'b1;
        else if (cur_ack) m_ch = 1'b0;
        m_sw = nsw;
        m_ks = nk;
        sw_h.push_back(cur_sw);
        key_h.push_back(cur_key);
        void'(sw_h.pop_front());
        void'(key_h.pop_front());
    endtask

    // One cycle: settle the previous edge in the model, apply new inputs, queue what must be visible.
    task automatic step(input logic [SW_W-1:0] s, input logic [KEY_W-1:0] k, input logic a, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        sw_raw = s; key_raw = k; sw_ack = a; rst = r;
        cur_sw = s; cur_key = k; cur_ack = a; cur_rst = r;
        if (r) model_reset();
        e.sw = m_sw; e.ks = m_ks; e.kp = m_kp; e.io = 32'(m_sw); e.ch = m_ch;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sw_stable", 32'(sw_stable), 32'(e.sw));
                check("key_stable", 32'(key_stable), 32'(e.ks));
                check("key_press", 32'(key_press), 32'(e.kp));
                check("io_word", io_word, e.io);
                check("sw_changed", 32'(sw_changed), 32'(e.ch));
            end
        end
    end

    initial begin : stimulus
        logic [SW_W-1:0]  s;
        logic [KEY_W-1:0] k;
        int               len;
        model_reset();
        // reset with switches already non-zero, then settle
        for (int i = 0; i < 3; i++) step(18'd12345, 4'hf, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(18'd12345, 4'hf, 1'b0, 1'b0);
        step(18'd12345, 4'hf, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(18'd12345, 4'hf, 1'b0, 1'b0);
        // short glitch, then a held change
        for (int i = 0; i < 3; i++) step(18'd12344, 4'hf, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(18'd12345, 4'hf, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(18'd12344, 4'hf, 1'b0, 1'b0);
        // key press and release
        for (int i = 0; i < 10; i++) step(18'd12344, 4'he, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(18'd12344, 4'hf, 1'b0, 1'b0);
        // long hold on key 1
        for (int i = 0; i < 30; i++) step(18'd12344, 4'hd, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(18'd12344, 4'hf, 1'b0, 1'b0);
        // ack asserted throughout an update, then a lone ack
        for (int i = 0; i < 10; i++) step(18'd12344 ^ 18'h20, 4'hf, 1'b1, 1'b0);
        step(18'd12344 ^ 18'h20, 4'hf, 1'b1, 1'b0);
        step(18'd12344 ^ 18'h20, 4'hf, 1'b0, 1'b0);
        // reset while a count is in flight
        for (int i = 0; i < 4; i++) step(18'h3ffff, 4'h0, 1'b0, 1'b0);
        step(18'h3ffff, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(18'h3ffff, 4'h0, 1'b0, 1'b0);
        // randomized segments
        s = 18'h3ffff; k = 4'h0;
        for (int seg = 0; seg < 250; seg++) begin
            s = s ^ SW_W'($urandom_range(0, 3) == 0 ? $urandom : (32'd1 << $urandom_range(0, SW_W - 1)));
            k = k ^ KEY_W'($urandom_range(0, 15));
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++)
                step(s, k, ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 10; i++) step(s, k, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
